// File: rtl/intpol2_job_sched.sv
// intpol2_job_sched: queues interpolator job descriptors, drives the core config/start,
// supervises done/stall with a watchdog and emits a completion record per job.
module intpol2_job_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int TO_W       = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic                      job_bypass,
  input  logic [DATA_WIDTH-1:0]     job_ix,
  input  logic [DATA_WIDTH-1:0]     job_ix2,
  input  logic [DATA_WIDTH-1:0]     job_len,
  input  logic [TO_W-1:0]           timeout_lim,
  input  logic                      abort,
  input  logic [7:0]                status_reg,
  output logic [4*DATA_WIDTH-1:0]   config_reg,
  output logic                      start,
  output logic                      core_rst,
  output logic                      cmpl_valid,
  output logic [1:0]                cmpl_code,
  output logic                      sched_busy,
  output logic [$clog2(DEPTH+1)-1:0] pending
);
  localparam int EW = 3*DATA_WIDTH+1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_ACK, S_RUN, S_BYP, S_CMPL, S_ERR} state_t;
  state_t r_state, w_next;
  logic [EW-1:0]         r_mem [DEPTH];
  logic [EW-1:0]         w_head;
  logic [PW-1:0]         r_wr, r_rd;
  logic [CW-1:0]         r_cnt;
  logic [TO_W-1:0]       r_wd, w_wd, w_wd_inc;
  logic [DATA_WIDTH-1:0] r_byp, w_byp;
  logic [1:0]            r_code, w_code;
  logic                  r_err;
  logic                  w_push, w_pop, w_done, w_busy, w_stall, w_to, w_unused;
  assign w_done    = status_reg[0];
  assign w_busy    = status_reg[1];
  assign w_stall   = status_reg[2] | status_reg[3];
  assign w_unused  = ^status_reg[7:4];
  assign job_ready = r_cnt < CW'(DEPTH);
  assign w_push    = job_valid & job_ready;
  assign w_pop     = r_state == S_IDLE && r_cnt != '0;
  assign w_head    = r_mem[r_rd];
  assign w_wd_inc  = &r_wd ? r_wd : r_wd + TO_W'(1);
  assign w_to      = timeout_lim != '0 && w_wd_inc >= timeout_lim;
  assign start      = r_state == S_START;
  assign core_rst   = r_state == S_ERR;
  assign cmpl_valid = r_state == S_CMPL;
  assign cmpl_code  = r_code;
  assign sched_busy = r_state != S_IDLE;
  assign pending    = r_cnt;
  always_comb begin
    w_next = r_state;
    w_code = r_code;
    w_wd   = r_wd;
    w_byp  = r_byp;
    case (r_state)
      S_IDLE:  w_next = w_pop ? S_LOAD : S_IDLE;
      S_LOAD: begin
        w_byp  = config_reg[4*DATA_WIDTH-1:3*DATA_WIDTH];
        w_next = config_reg[0] ? S_BYP : S_START;
      end
      S_START: begin
        w_wd   = '0;
        w_next = S_ACK;
      end
      S_ACK: begin
        w_wd = w_wd_inc;
        if (w_done) begin
          w_next = S_CMPL;
          w_code = 2'd0;
        end else if (w_to) begin
          w_next = S_CMPL;
          w_code = 2'd1;
        end else if (w_busy) begin
          w_next = S_RUN;
          w_wd   = '0;
        end
      end
      S_RUN: begin
        w_wd = w_stall ? w_wd_inc : '0;
        if (w_done) begin
          w_next = S_CMPL;
          w_code = 2'd0;
        end else if (w_stall && w_to) begin
          w_next = S_CMPL;
          w_code = 2'd1;
        end
      end
      S_BYP: begin
        w_byp = r_byp - DATA_WIDTH'(1);
        if (r_byp <= DATA_WIDTH'(1)) begin
          w_next = S_CMPL;
          w_code = 2'd0;
        end
      end
      S_CMPL:  w_next = r_code != 2'd0 ? S_ERR : S_IDLE;
      S_ERR:   w_next = r_err ? S_IDLE : S_ERR;
    endcase
    if (abort && r_state inside {S_LOAD, S_START, S_ACK, S_RUN, S_BYP}) begin
      w_next = S_CMPL;
      w_code = 2'd2;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {job_bypass, job_ix, job_ix2, job_len};
  end
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state    <= S_IDLE;
      r_wr       <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_wd       <= '0;
      r_byp      <= '0;
      r_code     <= '0;
      r_err      <= 1'b0;
      config_reg <= '0;
    end else begin
      r_state <= w_next;
      r_wd    <= w_wd;
      r_byp   <= w_byp;
      r_code  <= w_code;
      r_err   <= r_state == S_ERR && !r_err;
      r_cnt   <= r_cnt + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wr <= r_wr == PW'(DEPTH-1) ? '0 : r_wr + PW'(1);
      if (w_pop) begin
        r_rd       <= r_rd == PW'(DEPTH-1) ? '0 : r_rd + PW'(1);
        config_reg <= {w_head[DATA_WIDTH-1:0], w_head[2*DATA_WIDTH-1:DATA_WIDTH],
                       w_head[3*DATA_WIDTH-1:2*DATA_WIDTH], {(DATA_WIDTH-1){1'b0}}, w_head[EW-1]};
      end else if (r_state == S_CMPL && r_code != 2'd0) begin
        config_reg <= '0;
      end
    end
  end
endmodule

// File: tb/tb_intpol2_job_sched.sv
// tb_intpol2_job_sched: directed scenarios with a completion-code scoreboard.
module tb_intpol2_job_sched;
  logic         clk = 1'b0;
  logic         rstn;
  logic         job_valid;
  logic         job_ready;
  logic         job_bypass;
  logic [31:0]  job_ix, job_ix2, job_len;
  logic [15:0]  timeout_lim;
  logic         abort;
  logic [7:0]   status_reg;
  logic [127:0] config_reg;
  logic         start, core_rst, cmpl_valid;
  logic [1:0]   cmpl_code;
  logic         sched_busy;
  logic [2:0]   pending;
  int           n_chk = 0;
  int           n_fail = 0;
  int           n_cmpl = 0;
  int           n_start = 0;
  logic [1:0]   sb [$];

  intpol2_job_sched dut (
    .clk(clk), .rstn(rstn), .job_valid(job_valid), .job_ready(job_ready),
    .job_bypass(job_bypass), .job_ix(job_ix), .job_ix2(job_ix2), .job_len(job_len),
    .timeout_lim(timeout_lim), .abort(abort), .status_reg(status_reg),
    .config_reg(config_reg), .start(start), .core_rst(core_rst),
    .cmpl_valid(cmpl_valid), .cmpl_code(cmpl_code), .sched_busy(sched_busy),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic put_job(input logic b, input logic [31:0] ix, input logic [31:0] ix2, input logic [31:0] len);
    job_valid  = 1'b1;
    job_bypass = b;
    job_ix     = ix;
    job_ix2    = ix2;
    job_len    = len;
  endtask

  task automatic wait_start();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (start) return;
    end
    chk("start_wait", start, 1);
  endtask

  always @(negedge clk) begin
    if (start) n_start++;
    if (cmpl_valid) begin
      n_cmpl++;
      if (sb.size() == 0) chk("cmpl_unexpected", cmpl_valid, 0);
      else chk("cmpl_code", cmpl_code, sb.pop_front());
    end
  end

  initial begin
    int base;
    bit exp_rdy [6];
    exp_rdy = '{1, 1, 1, 1, 1, 0};
    rstn = 1'b1; job_valid = 1'b0; job_bypass = 1'b0; job_ix = '0; job_ix2 = '0; job_len = '0;
    timeout_lim = '0; abort = 1'b0; status_reg = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    chk("rst_cfg", config_reg, 0);
    chk("rst_ready", job_ready, 1);
    chk("rst_pending", pending, 0);
    chk("rst_busy", sched_busy, 0);
    chk("rst_outs", {start, core_rst, cmpl_valid, cmpl_code}, 0);

    // normal job
    @(negedge clk);
    put_job(0, 32'h2000_0000, 32'h0800_0000, 32'd16);
    sb.push_back(2'd0);
    for (int c = 1; c <= 42; c++) begin
      @(negedge clk);
      if (c == 1) begin job_valid = 1'b0; chk("norm_pend", pending, 1); end
      if (c == 2) chk("norm_cfg", config_reg, {32'd16, 32'h0800_0000, 32'h2000_0000, 32'h0});
      if (c == 3) chk("norm_start", start, 1);
      if (c == 4) chk("norm_start_pulse", start, 0);
      if (c == 5) status_reg = 8'h02;
      if (c == 40) begin chk("norm_early", cmpl_valid, 0); status_reg = 8'h03; end
      if (c == 41) begin chk("norm_cmpl", cmpl_valid, 1); status_reg = 8'h00; end
      if (c == 42) chk("norm_no_err", core_rst, 0);
    end

    // fill and backpressure: core never acknowledges
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("fill_rdy%0d", k), job_ready, exp_rdy[k]);
      put_job(0, k, k, 32'd16);
    end
    @(negedge clk);
    job_valid = 1'b0;
    chk("fill_pend", pending, 4);
    chk("fill_full", job_ready, 0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        wait_start();
        chk($sformatf("fill_ix%0d", k), config_reg[63:32], k);
      end
      @(negedge clk);
      abort = 1'b1;
      sb.push_back(2'd2);
      @(negedge clk);
      abort = 1'b0;
    end
    repeat (8) @(negedge clk);
    chk("fill_drained", {sched_busy, pending}, 0);
    chk("fill_ready", job_ready, 1);

    // bypass jobs, len 5 then len 0
    @(negedge clk);
    base = n_start;
    put_job(1, 32'hA, 32'hB, 32'd5);
    sb.push_back(2'd0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) job_valid = 1'b0;
      if (c == 2) chk("byp_len", config_reg[127:96], 5);
      if (c >= 2 && c <= 7) chk($sformatf("byp_flag%0d", c), config_reg[0], 1);
      if (c == 7) chk("byp_early", cmpl_valid, 0);
      if (c == 8) chk("byp_cmpl", cmpl_valid, 1);
    end
    put_job(1, 32'hC, 32'hD, 32'd0);
    sb.push_back(2'd0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) job_valid = 1'b0;
      if (c == 3) chk("byp0_early", cmpl_valid, 0);
      if (c == 4) chk("byp0_cmpl", cmpl_valid, 1);
    end
    chk("byp_no_start", n_start - base, 0);

    // stall timeout, limit 8, with a second job queued behind it
    @(negedge clk);
    timeout_lim = 16'd8;
    put_job(0, 32'd1, 32'd1, 32'd16);
    sb.push_back(2'd1);
    sb.push_back(2'd0);
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      if (c == 1) put_job(0, 32'd2, 32'd4, 32'd16);
      if (c == 2) job_valid = 1'b0;
      if (c == 3) chk("to_start", start, 1);
      if (c == 4) status_reg = 8'h06;
      if (c == 12) chk("to_early", cmpl_valid, 0);
      if (c == 13) begin chk("to_cmpl", cmpl_valid, 1); status_reg = 8'h00; end
      if (c == 14) begin chk("to_rst1", core_rst, 1); chk("to_cfg_clr", config_reg, 0); end
      if (c == 15) chk("to_rst2", core_rst, 1);
      if (c == 16) chk("to_rst_end", core_rst, 0);
      if (c == 18) begin chk("to_next_start", start, 1); chk("to_next_ix", config_reg[63:32], 2); end
      if (c == 19) status_reg = 8'h02;
      if (c == 25) status_reg = 8'h03;
      if (c == 26) begin chk("to_next_cmpl", cmpl_valid, 1); status_reg = 8'h00; end
    end

    // watchdog disabled: long stall never times out
    @(negedge clk);
    timeout_lim = 16'd0;
    base = n_cmpl;
    put_job(0, 32'd3, 32'd9, 32'd16);
    sb.push_back(2'd0);
    for (int c = 1; c <= 62; c++) begin
      @(negedge clk);
      if (c == 1) job_valid = 1'b0;
      if (c == 4) status_reg = 8'h06;
      if (c == 60) begin chk("nto_none", n_cmpl - base, 0); status_reg = 8'h07; end
      if (c == 61) begin chk("nto_cmpl", cmpl_valid, 1); status_reg = 8'h00; end
    end

    // abort and done in the same RUN cycle
    @(negedge clk);
    put_job(0, 32'd5, 32'd25, 32'd16);
    sb.push_back(2'd2);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) job_valid = 1'b0;
      if (c == 4) status_reg = 8'h02;
      if (c == 7) begin status_reg = 8'h03; abort = 1'b1; end
      if (c == 8) begin abort = 1'b0; status_reg = 8'h00; chk("ab_cmpl", cmpl_valid, 1); end
      if (c == 9) chk("ab_rst1", core_rst, 1);
      if (c == 10) chk("ab_rst2", core_rst, 1);
      if (c == 11) chk("ab_idle", {core_rst, sched_busy}, 0);
    end

    // reset while running with two jobs queued
    @(negedge clk);
    base = n_cmpl;
    put_job(0, 32'd6, 32'd36, 32'd16);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) put_job(0, 32'd7, 32'd49, 32'd16);
      if (c == 2) put_job(0, 32'd8, 32'd64, 32'd16);
      if (c == 3) begin job_valid = 1'b0; chk("mr_pend", pending, 2); end
      if (c == 4) status_reg = 8'h02;
      if (c == 6) begin rstn = 1'b1; status_reg = 8'h00; end
      if (c == 7) begin
        rstn = 1'b0;
        chk("mr_cfg", config_reg, 0);
        chk("mr_outs", {start, core_rst, cmpl_valid, cmpl_code}, 0);
        chk("mr_busy_pend", {sched_busy, pending}, 0);
        chk("mr_ready", job_ready, 1);
      end
    end
    repeat (10) @(negedge clk);
    chk("mr_idle", sched_busy, 0);
    chk("mr_no_cmpl", n_cmpl - base, 0);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
